updown_bounded_counter: RTL and testbench
=========================================

# updown_bounded_counter

Parametrised up/down counter for the sequence-generator blocks: the successor to the basic N-bit up/down counter. It adds programmable lower/upper bounds, a programmable step, synchronous parallel load, and a selectable wrap or saturate mode at the bounds. Registered terminal-count and bound flags drive downstream sequencers and pattern generators.

## Interface
- N, default 4: counter and bound width in bits (N ≥ 2).
- RST_VAL, default 0: value loaded into count on reset (N bits).

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  advance count by one step this cycle.
- up_down  input  1  1 = count up, 0 = count down.
- mode  input  1  0 = wrap at bounds, 1 = saturate at bounds.
- load  input  1  synchronous parallel load, sampled at the clock edge.
- load_val  input  N  value written to count when load = 1.
- step  input  N  increment/decrement magnitude, unsigned.
- min_val  input  N  inclusive lower bound, unsigned.
- max_val  input  N  inclusive upper bound, unsigned.
- count  output  N  current count, registered.
- tc  output  1  registered pulse: the last update hit a bound (wrapped or clamped).
- at_max  output  1  combinational: count == max_val.
- at_min  output  1  combinational: count == min_val.
- cfg_err  output  1  combinational: min_val > max_val.

## Operation
- Reset (rst = 0, asynchronous): count = RST_VAL and tc = 0. at_max, at_min and cfg_err follow their definitions from the reset count.
- Priority at each rising edge: load > cfg_err hold > enable step > hold.
- Load:
  - count ← load_val unmodified, even if outside [min_val, max_val].
  - tc ← 0.
  - load wins over a simultaneous enable.
- cfg_err = 1 with no load: count holds and tc ← 0.
- enable = 0, or step = 0 (with no load): count holds and tc ← 0.
- All arithmetic is unsigned in N+1 bits, so there is no silent modular wrap.
- Step up (up_down = 1), with sum = count + step:
  - sum ≤ max_val: count ← sum, tc ← 0.
  - sum > max_val, wrap mode: count ← min_val, tc ← 1.
  - sum > max_val, saturate mode: count ← max_val, tc ← 1.
- Step down (up_down = 0), with diff = count − step, underflow detected as count < min_val + step:
  - No underflow: count ← diff, tc ← 0.
  - Underflow, wrap mode: count ← max_val, tc ← 1.
  - Underflow, saturate mode: count ← min_val, tc ← 1.
- Wrap discards the overshoot remainder; the sequence restarts exactly at the opposite bound.
- Saturate: every enabled step attempted at the bound re-asserts tc, so tc stays high while pinned and enabled.
- Out-of-range count after a load: the rules above apply unchanged.
  - Up step from count > max_val wraps/clamps with tc = 1.
  - Down step from count < min_val wraps/clamps with tc = 1.
- min_val == max_val: any nonzero enabled step yields count = min_val and tc = 1.
- up_down, mode, step and bounds may change on any cycle; each edge uses only the values sampled at that edge.

## Timing
- Single clock domain; all state updates on the rising edge of clk.
- count and tc have one-cycle latency from sampled inputs. tc is cycle-aligned with the count value it describes.
- at_max, at_min and cfg_err are zero-latency combinational functions of count and the live bound inputs.
- Reset asserts asynchronously. Deassertion is synchronised externally; the first update can occur on the first edge after rst goes high.
- Reset mid-sequence clears tc immediately and forces count = RST_VAL, overriding any pending load or step.

## Test plan
- N = 4, min = 3, max = 12, step = 4, wrap, up, count loaded 3, enable held → count 7, 11, 3 (tc = 1 on the 3 only), 7.
- Same bounds, saturate, down, load 6, step 2 → count 4, 3 (tc = 1), 3 (tc = 1), 3 (tc = 1); at_min = 1 from the first 3 onward.
- load = 1 and enable = 1 together, load_val = 9 → count = 9 next cycle, tc = 0; then load_val = 15 > max = 12 and one up step → count = 3, tc = 1 (wrap).
- Set min = 10, max = 5 → cfg_err = 1 and count holds through 5 enabled cycles. Restore max = 12 → counting resumes.
- Assert rst mid-count at count = 11 with RST_VAL = 0 → count = 0 and tc = 0 immediately, not waiting for a clock edge.
- step = 0 with enable high for 4 cycles → count unchanged, tc = 0. Also, N = 4, max = 15, count = 14, step = 3, up, wrap → no modular alias; count = min, tc = 1.

Source files
------------

// File: rtl/updown_bounded_counter.sv
// Up/down counter with programmable [min_val, max_val] bounds, step, parallel load
// and wrap/saturate behaviour. tc pulses on the cycle the count hit a bound.
module updown_bounded_counter #(
   parameter int unsigned    N       = 4,
   parameter logic [N-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         up_down,
   input  logic         mode,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic [N-1:0] step,
   input  logic [N-1:0] min_val,
   input  logic [N-1:0] max_val,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         at_max,
   output logic         at_min,
   output logic         cfg_err
);

   logic [N:0]   sum;
   logic [N:0]   min_plus_step;
   logic [N-1:0] diff;
   logic         overflow;
   logic         underflow;
   logic [N-1:0] count_nxt;
   logic         tc_nxt;

   assign at_max  = (count == max_val);
   assign at_min  = (count == min_val);
   assign cfg_err = (min_val > max_val);

   // One extra bit keeps count+step and min_val+step from aliasing modulo 2^N.
   assign sum           = {1'b0, count} + {1'b0, step};
   assign min_plus_step = {1'b0, min_val} + {1'b0, step};
   assign diff          = count - step;
   assign overflow      = (sum > {1'b0, max_val});
   assign underflow     = ({1'b0, count} < min_plus_step);

   always_comb begin
      count_nxt = count;
      tc_nxt    = 1'b0;
      if (load) begin
         count_nxt = load_val;
      end else if (!cfg_err && enable && (step != '0)) begin
         if (up_down) begin
            if (!overflow) begin
               count_nxt = sum[N-1:0];
            end else begin
               count_nxt = mode ? max_val : min_val;
               tc_nxt    = 1'b1;
            end
         end else begin
            if (!underflow) begin
               count_nxt = diff;
            end else begin
               count_nxt = mode ? min_val : max_val;
               tc_nxt    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= RST_VAL;
         tc    <= 1'b0;
      end else begin
         count <= count_nxt;
         tc    <= tc_nxt;
      end
   end

endmodule

// File: tb/tb_updown_bounded_counter.sv
// Directed bench for updown_bounded_counter (N = 4, RST_VAL = 0).
module tb_updown_bounded_counter;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         enable;
   logic         up_down;
   logic         mode;
   logic         load;
   logic [N-1:0] load_val;
   logic [N-1:0] step;
   logic [N-1:0] min_val;
   logic [N-1:0] max_val;
   logic [N-1:0] count;
   logic         tc;
   logic         at_max;
   logic         at_min;
   logic         cfg_err;

   int checks = 0;
   int errors = 0;

   updown_bounded_counter #(.N(N), .RST_VAL(4'd0)) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .up_down  (up_down),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .step     (step),
      .min_val  (min_val),
      .max_val  (max_val),
      .count    (count),
      .tc       (tc),
      .at_max   (at_max),
      .at_min   (at_min),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_chk(input string tag, input int exp_count, input int exp_tc);
      tick();
      check({tag, "_count"}, 32'(count), 32'(exp_count));
      check({tag, "_tc"}, 32'(tc), 32'(exp_tc));
   endtask

   initial begin
      rst      = 1'b0;
      enable   = 1'b0;
      up_down  = 1'b1;
      mode     = 1'b0;
      load     = 1'b0;
      load_val = '0;
      step     = 4'd4;
      min_val  = 4'd3;
      max_val  = 4'd12;
      #12;
      check("rst_count", 32'(count), 0);
      check("rst_tc", 32'(tc), 0);
      check("rst_at_min", 32'(at_min), 0);
      check("rst_at_max", 32'(at_max), 0);
      check("rst_cfg_err", 32'(cfg_err), 0);
      rst = 1'b1;

      // wrap up from 3 with step 4; load wins over enable
      load = 1'b1; load_val = 4'd3; enable = 1'b1;
      tick_chk("wrap_load", 3, 0);
      check("wrap_load_at_min", 32'(at_min), 1);
      load = 1'b0;
      tick_chk("wrap_up1", 7, 0);
      tick_chk("wrap_up2", 11, 0);
      tick_chk("wrap_up3", 3, 1);
      tick_chk("wrap_up4", 7, 0);

      // saturate down from 6 with step 2
      mode = 1'b1; up_down = 1'b0; step = 4'd2;
      load = 1'b1; load_val = 4'd6;
      tick_chk("sat_load", 6, 0);
      load = 1'b0;
      tick_chk("sat_dn1", 4, 0);
      check("sat_dn1_at_min", 32'(at_min), 0);
      tick_chk("sat_dn2", 3, 1);
      check("sat_dn2_at_min", 32'(at_min), 1);
      tick_chk("sat_dn3", 3, 1);
      tick_chk("sat_dn4", 3, 1);

      // load over enable, then up step from above max wraps
      mode = 1'b0; up_down = 1'b1; step = 4'd4;
      load = 1'b1; load_val = 4'd9;
      tick_chk("ld_pri", 9, 0);
      load_val = 4'd15;
      tick_chk("ld_oor", 15, 0);
      check("ld_oor_at_max", 32'(at_max), 0);
      load = 1'b0;
      tick_chk("oor_up", 3, 1);

      // wrap down underflow
      load = 1'b1; load_val = 4'd4; up_down = 1'b0; step = 4'd2;
      tick_chk("wdn_load", 4, 0);
      load = 1'b0;
      tick_chk("wdn_step", 12, 1);
      check("wdn_at_max", 32'(at_max), 1);

      // saturate up at max
      load = 1'b1; load_val = 4'd11; up_down = 1'b1; mode = 1'b1; step = 4'd4;
      tick_chk("sup_load", 11, 0);
      load = 1'b0;
      tick_chk("sup_1", 12, 1);
      tick_chk("sup_2", 12, 1);

      // min == max
      min_val = 4'd5; max_val = 4'd5; step = 4'd1;
      tick_chk("eq_up", 5, 1);
      up_down = 1'b0;
      tick_chk("eq_dn", 5, 1);
      check("eq_at_both", 32'({at_min, at_max}), 3);

      // configuration error holds the count
      load = 1'b1; load_val = 4'd3; mode = 1'b0; up_down = 1'b1; step = 4'd4;
      min_val = 4'd3; max_val = 4'd12;
      tick_chk("cfg_load", 3, 0);
      load = 1'b0;
      min_val = 4'd10; max_val = 4'd5;
      #1;
      check("cfg_err_set", 32'(cfg_err), 1);
      for (int i = 0; i < 5; i++) tick_chk("cfg_hold", 3, 0);
      max_val = 4'd12;
      #1;
      check("cfg_err_clr", 32'(cfg_err), 0);
      tick_chk("cfg_resume1", 7, 0);
      tick_chk("cfg_resume2", 11, 0);

      // asynchronous reset mid-count, overriding a pending load
      load = 1'b1; load_val = 4'd9;
      rst = 1'b0;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_tc", 32'(tc), 0);
      tick();
      check("arst_hold", 32'(count), 0);
      load = 1'b0;
      rst = 1'b1;

      // step 0 holds even with enable
      min_val = 4'd3; max_val = 4'd12; step = 4'd0;
      for (int i = 0; i < 4; i++) tick_chk("step0", 0, 0);

      // no modular alias: 14 + 3 must wrap to min
      max_val = 4'd15; load = 1'b1; load_val = 4'd14;
      tick_chk("alias_load", 14, 0);
      load = 1'b0; step = 4'd3;
      tick_chk("alias_up", 3, 1);

      // reset clears a high tc without a clock edge
      rst = 1'b0;
      #1;
      check("arst_tc_clr", 32'(tc), 0);
      check("arst_count2", 32'(count), 0);
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got 0 expected 1");
      $fatal(1);
   end

endmodule
